// File: rtl/blink_pattern_decoder.sv
// Receive side of the on/off beacon: debounces KEY, measures mark/space lengths
// in beacon units, decodes marks into dots/dashes and emits one word per character.
module blink_pattern_decoder #(
  parameter int unsigned UNIT_CYCLES     = 2097152,
  parameter int unsigned DEBOUNCE_CYCLES = 16000,
  parameter int unsigned DASH_MIN        = 2,
  parameter int unsigned CHAR_GAP        = 3,
  parameter int unsigned MAX_ELEM        = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                KEY,
  output logic                KEY_LEVEL,
  output logic                CHAR_VALID,
  output logic [MAX_ELEM-1:0] CHAR_BITS,
  output logic [2:0]          CHAR_LEN,
  output logic                CHAR_ERR
);

  localparam int unsigned PHASE_W = $clog2(UNIT_CYCLES);
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned UNIT_W  = 4;
  localparam int unsigned LEN_W   = UNIT_W + 1;
  localparam int unsigned ELEM_W  = 3;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(UNIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(UNIT_CYCLES / 2);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LEN_W-1:0]   DASH_LEN   = LEN_W'(DASH_MIN);
  localparam logic [LEN_W-1:0]   GAP_LEN    = LEN_W'(CHAR_GAP);
  localparam logic [ELEM_W-1:0]  ELEM_MAX   = ELEM_W'(MAX_ELEM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_SPACE
  } state_t;

  logic                key_s1;
  logic                key_s2;
  logic [DB_W-1:0]     db_cnt;
  logic                key_toggle_c;
  logic                rise_c;
  logic                fall_c;
  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W-1:0]  phase_nxt;
  logic [UNIT_W-1:0]   units;
  logic [UNIT_W-1:0]   units_nxt;
  logic [LEN_W-1:0]    len_r_c;
  logic                dash_c;
  logic                gap_c;
  state_t              state;
  logic [MAX_ELEM-1:0] elem_bits;
  logic [ELEM_W-1:0]   elem_cnt;
  logic                elem_err;
  logic                emit_q;

  // Two-flop synchronizer for the raw switch line
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
    end
  end

  assign key_toggle_c = (key_s2 != KEY_LEVEL) && (db_cnt == DB_LAST);
  assign rise_c       = key_toggle_c && key_s2;
  assign fall_c       = key_toggle_c && !key_s2;

  // Debouncer: any sample agreeing with KEY_LEVEL restarts the count
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db_cnt    <= '0;
      KEY_LEVEL <= 1'b0;
    end else if (key_s2 == KEY_LEVEL) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt    <= '0;
      KEY_LEVEL <= key_s2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Elapsed length counts the current cycle, so R is formed from the advanced counters
  always_comb begin
    phase_nxt = phase + 1'b1;
    units_nxt = units;
    if (phase == PHASE_LAST) begin
      phase_nxt = '0;
      if (units != '1) begin
        units_nxt = units + 1'b1;
      end
    end
    len_r_c = {1'b0, units_nxt} + LEN_W'(phase_nxt >= PHASE_HALF);
  end

  assign dash_c = (len_r_c >= DASH_LEN);
  assign gap_c  = (len_r_c >= GAP_LEN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase <= '0;
      units <= '0;
    end else if (key_toggle_c) begin
      phase <= '0;
      units <= '0;
    end else begin
      phase <= phase_nxt;
      units <= units_nxt;
    end
  end

  // Element collection and character emit; the strobe follows the SPACE->IDLE step
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      elem_bits  <= '0;
      elem_cnt   <= '0;
      elem_err   <= 1'b0;
      emit_q     <= 1'b0;
      CHAR_VALID <= 1'b0;
      CHAR_BITS  <= '0;
      CHAR_LEN   <= '0;
      CHAR_ERR   <= 1'b0;
    end else begin
      CHAR_VALID <= 1'b0;
      emit_q     <= 1'b0;
      if (emit_q) begin
        CHAR_VALID <= 1'b1;
        CHAR_BITS  <= elem_bits;
        CHAR_LEN   <= elem_cnt;
        CHAR_ERR   <= elem_err;
        elem_bits  <= '0;
        elem_cnt   <= '0;
        elem_err   <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (rise_c) begin
            state <= S_MARK;
          end
        end
        S_MARK: begin
          if (fall_c) begin
            state <= S_SPACE;
            if (elem_cnt < ELEM_MAX) begin
              elem_bits[elem_cnt] <= dash_c;
              elem_cnt            <= elem_cnt + 1'b1;
            end else begin
              elem_err <= 1'b1;
            end
          end
        end
        S_SPACE: begin
          // A rise coinciding with the gap threshold keeps the character open
          if (rise_c) begin
            state <= S_MARK;
          end else if (gap_c) begin
            state  <= S_IDLE;
            emit_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_pattern_decoder.sv
// Bench for blink_pattern_decoder: keying table plus reset/glitch sequences,
// with expected characters queued at drive time and checked on each strobe.
module tb_blink_pattern_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       KEY;
  logic       KEY_LEVEL;
  logic       CHAR_VALID;
  logic [5:0] CHAR_BITS;
  logic [2:0] CHAR_LEN;
  logic       CHAR_ERR;

  always #5 CLK = ~CLK;

  blink_pattern_decoder #(
    .UNIT_CYCLES    (8),
    .DEBOUNCE_CYCLES(4),
    .DASH_MIN       (2),
    .CHAR_GAP       (3),
    .MAX_ELEM       (6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .KEY       (KEY),
    .KEY_LEVEL (KEY_LEVEL),
    .CHAR_VALID(CHAR_VALID),
    .CHAR_BITS (CHAR_BITS),
    .CHAR_LEN  (CHAR_LEN),
    .CHAR_ERR  (CHAR_ERR)
  );

  typedef struct {
    int         mark;
    int         space;
    bit         emit;
    logic [5:0] bits;
    logic [2:0] len;
    logic       err;
  } vec_t;

  typedef struct {
    logic [5:0] bits;
    logic [2:0] len;
    logic       err;
  } exp_t;

  localparam int EMIT_DELAY = 21;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    KEY = lvl;
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_exp(input logic [5:0] bits, input logic [2:0] len, input logic err);
    exp_t e;
    e.bits = bits;
    e.len  = len;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_key_level"},  32'(KEY_LEVEL),  0);
    check({tag, "_char_valid"}, 32'(CHAR_VALID), 0);
    check({tag, "_char_bits"},  32'(CHAR_BITS),  0);
    check({tag, "_char_len"},   32'(CHAR_LEN),   0);
    check({tag, "_char_err"},   32'(CHAR_ERR),   0);
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    check({tag, "_pending_chars"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    vec_t vecs[$];
    logic seen;

    // SOS
    vecs.push_back('{8,  8,  1'b0, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{8,  8,  1'b0, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{8,  24, 1'b1, 6'b000000, 3'd3, 1'b0});
    vecs.push_back('{24, 8,  1'b0, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{24, 8,  1'b0, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{24, 24, 1'b1, 6'b000111, 3'd3, 1'b0});
    vecs.push_back('{8,  8,  1'b0, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{8,  8,  1'b0, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{8,  30, 1'b1, 6'b000000, 3'd3, 1'b0});
    // Rounding boundary
    vecs.push_back('{11, 30, 1'b1, 6'b000000, 3'd1, 1'b0});
    vecs.push_back('{12, 30, 1'b1, 6'b000001, 3'd1, 1'b0});
    // Gap boundary: 19 keeps the character, 21 closes it
    vecs.push_back('{8,  19, 1'b0, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{8,  30, 1'b1, 6'b000000, 3'd2, 1'b0});
    vecs.push_back('{8,  21, 1'b1, 6'b000000, 3'd1, 1'b0});
    vecs.push_back('{8,  30, 1'b1, 6'b000000, 3'd1, 1'b0});
    // Overflow then a clean dash
    for (int i = 0; i < 6; i++) vecs.push_back('{8, 8, 1'b0, 6'b000000, 3'd0, 1'b0});
    vecs.push_back('{8,  30, 1'b1, 6'b000000, 3'd6, 1'b1});
    vecs.push_back('{24, 30, 1'b1, 6'b000001, 3'd1, 1'b0});

    fork
      begin : monitor
        logic prev_lvl;
        logic prev_val;
        int   fall_cyc;
        exp_t e;
        prev_lvl = 1'b0;
        prev_val = 1'b0;
        fall_cyc = 0;
        forever begin
          @(negedge CLK);
          if (prev_lvl && !KEY_LEVEL) fall_cyc = cyc;
          if (prev_val) check("strobe_width", 32'(CHAR_VALID), 0);
          if (CHAR_VALID) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_char: got len=%0d bits=%b err=%0d, required no strobe (cycle %0d)",
                       CHAR_LEN, CHAR_BITS, CHAR_ERR, cyc);
            end else begin
              e = exp_q.pop_front();
              check("char_len",   32'(CHAR_LEN),  32'(e.len));
              check("char_bits",  32'(CHAR_BITS), 32'(e.bits));
              check("char_err",   32'(CHAR_ERR),  32'(e.err));
              check("emit_delay", 32'(cyc - fall_cyc), 32'(EMIT_DELAY));
            end
          end
          prev_lvl = KEY_LEVEL;
          prev_val = CHAR_VALID;
        end
      end
    join_none

    RST = 1'b1;
    KEY = 1'b0;
    repeat (3) @(negedge CLK);
    check_zero_outputs("reset");
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // Short pulse must never reach KEY_LEVEL
    seen = 1'b0;
    KEY  = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      seen = seen | KEY_LEVEL;
    end
    KEY = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      seen = seen | KEY_LEVEL;
    end
    check("glitch_level", 32'(seen), 0);

    foreach (vecs[i]) begin
      if (vecs[i].emit) push_exp(vecs[i].bits, vecs[i].len, vecs[i].err);
      drive(1'b1, vecs[i].mark);
      drive(1'b0, vecs[i].space);
    end
    wait_drain("table");

    // Reset mid-character: the pending dot is discarded
    drive(1'b1, 8);
    drive(1'b0, 8);
    KEY = 1'b1;
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("post_reset_level_early", 32'(KEY_LEVEL), 0);
    @(posedge CLK);
    #1;
    check("post_reset_level_rise", 32'(KEY_LEVEL), 1);
    @(negedge CLK);
    push_exp(6'b000001, 3'd1, 1'b0);
    drive(1'b1, 20);
    drive(1'b0, 30);
    wait_drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
